// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared definitions for the pipeline hazard/stall controller.
//               Holds the forwarding select codes, the halt FSM encoding and
//               the scoreboard entry type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  // Register index width carried in each scoreboard entry.
  localparam int RF_IDX_W = 5;

  // Operand source select codes (nearest producer has the lowest code).
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Debug halt / drain FSM.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // One in-flight register write, tracked per pipeline stage.
  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard/stall
//               controller.
// Ports       : master - pipeline side: drives ID-stage decode info, branch
//                        resolution and halt request; receives enables,
//                        flush/bubble, forwarding selects and status.
//               slave  - controller side (mirror of master).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [REG_W-1:0] ID_rd;
  logic             ID_RF_Enable;
  logic             ID_Load_Instr;
  logic             EX_Branch_Taken;
  logic             Halt_Req;
  logic             PC_LE;
  logic             IFID_LE;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic             Halted;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd, ID_RF_Enable,
           ID_Load_Instr, EX_Branch_Taken, Halt_Req,
    input  PC_LE, IFID_LE, IFID_Flush, IDEX_Bubble, FWD_A, FWD_B, Halted,
           Stall_Count, Flush_Count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd, ID_RF_Enable,
           ID_Load_Instr, EX_Branch_Taken, Halt_Req,
    output PC_LE, IFID_LE, IFID_Flush, IDEX_Bubble, FWD_A, FWD_B, Halted,
           Stall_Count, Flush_Count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sb_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sb_match
// Description : Combinational comparator of one ID source operand against the
//               EX/MEM/WB scoreboard entries. Returns the per-stage match
//               vector and the nearest-first forward select.
// Ports       : i_rs, i_rs_used          - operand index and read flag
//               i_sb_ex/i_sb_mem/i_sb_wb - scoreboard entries
//               o_match                  - {WB, MEM, EX} match bits
//               o_fwd                    - operand source select
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = RF_IDX_W
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_rs_used,
  input  sb_entry_t        i_sb_ex,
  input  sb_entry_t        i_sb_mem,
  input  sb_entry_t        i_sb_wb,
  output logic [2:0]       o_match,
  output logic [1:0]       o_fwd
);

  // x0 is hard-wired zero, so it never depends on an in-flight write.
  logic w_live;
  assign w_live = i_rs_used & (i_rs != '0);

  assign o_match[0] = w_live & i_sb_ex.valid  & (i_sb_ex.rd  == i_rs);
  assign o_match[1] = w_live & i_sb_mem.valid & (i_sb_mem.rd == i_rs);
  assign o_match[2] = w_live & i_sb_wb.valid  & (i_sb_wb.rd  == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (o_match[0]) begin
      // Load data is not ready in EX; the caller stalls, so nothing to forward.
      o_fwd = i_sb_ex.is_load ? FWD_RF : FWD_EX;
    end else if (o_match[1]) begin
      o_fwd = FWD_MEM;
    end else if (o_match[2]) begin
      o_fwd = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencing controller. Tracks in-flight writes in a
//               3-entry EX/MEM/WB scoreboard, generates forwarding selects,
//               load-use stalls, branch flushes and a debug halt/drain FSM,
//               plus saturating stall/flush event counters.
// Ports       : clk   - rising-edge clock
//               Reset - synchronous active-low reset
//               bus   - controller side of hazard_stall_ctrl_if
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = RF_IDX_W
) (
  input  logic                clk,
  input  logic                Reset,
  hazard_stall_ctrl_if.slave  bus
);

  sb_entry_t        r_sb_ex, r_sb_mem, r_sb_wb;
  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  sb_entry_t  w_sb_ex_nxt;
  state_t     w_state_nxt;
  logic [2:0] w_match_a, w_match_b;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_load_use, w_stall_evt, w_sb_idle;
  logic       w_pc_le, w_ifid_le, w_ifid_flush, w_idex_bubble;

  hazard_sb_match #(.REG_W(REG_W)) u_match_a (
    .i_rs     (bus.ID_rs1),
    .i_rs_used(bus.ID_rs1_used),
    .i_sb_ex  (r_sb_ex),
    .i_sb_mem (r_sb_mem),
    .i_sb_wb  (r_sb_wb),
    .o_match  (w_match_a),
    .o_fwd    (w_fwd_a)
  );

  hazard_sb_match #(.REG_W(REG_W)) u_match_b (
    .i_rs     (bus.ID_rs2),
    .i_rs_used(bus.ID_rs2_used),
    .i_sb_ex  (r_sb_ex),
    .i_sb_mem (r_sb_mem),
    .i_sb_wb  (r_sb_wb),
    .o_match  (w_match_b),
    .o_fwd    (w_fwd_b)
  );

  assign w_load_use  = (w_match_a[0] | w_match_b[0]) & r_sb_ex.is_load;
  // A taken branch discards the instruction in ID, so its hazard is moot.
  assign w_stall_evt = w_load_use & ~bus.EX_Branch_Taken;
  assign w_sb_idle   = ~(r_sb_ex.valid | r_sb_mem.valid | r_sb_wb.valid);
  assign w_sb_ex_nxt = {bus.ID_RF_Enable & (bus.ID_rd != '0), bus.ID_rd,
                        bus.ID_Load_Instr};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pipeline control outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_le       = 1'b1;
    w_ifid_le     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;

    if (!Reset) begin
      w_pc_le       = 1'b0;
      w_ifid_le     = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (bus.EX_Branch_Taken) begin
      // PC takes the branch target while the wrong-path fetch is squashed.
      w_ifid_le     = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_load_use || (r_state != ST_RUN)) begin
      w_pc_le       = 1'b0;
      w_ifid_le     = 1'b0;
      w_idex_bubble = 1'b1;
    end

    case (r_state)
      ST_RUN: begin
        if (bus.Halt_Req && !bus.EX_Branch_Taken) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.Halt_Req)  w_state_nxt = ST_RUN;
        else if (w_sb_idle) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (!bus.Halt_Req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Scoreboard shift and saturating event counters
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_sb_ex     <= '0;
      r_sb_mem    <= '0;
      r_sb_wb     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      r_sb_ex  <= w_idex_bubble ? '0 : w_sb_ex_nxt;
      if (bus.EX_Branch_Taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_LE       = w_pc_le;
  assign bus.IFID_LE     = w_ifid_le;
  assign bus.IFID_Flush  = w_ifid_flush;
  assign bus.IDEX_Bubble = w_idex_bubble;
  assign bus.FWD_A       = Reset ? w_fwd_a : FWD_RF;
  assign bus.FWD_B       = Reset ? w_fwd_b : FWD_RF;
  assign bus.Halted      = Reset & (r_state == ST_HALTED);
  assign bus.Stall_Count = r_stall_cnt;
  assign bus.Flush_Count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl: directed scenarios
//               plus randomized traffic against a behavioural model of the
//               in-flight write list, halt mode and event counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int CW   = 4;
  localparam int RW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(RW), .CNT_W(CW)) bus ();
  hazard_stall_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
    .clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: in-flight writes by age (0 = in EX, 1 = MEM, 2 = WB).
  bit m_v[3];
  int m_rd[3];
  bit m_ld[3];
  int m_mode;    // 0 running, 1 draining, 2 halted
  int m_stall, m_flush;

  bit e_pc, e_ifid, e_fl, e_bub, e_halt, e_lu;
  int e_fa, e_fb;

  // Age+1 of the youngest in-flight writer of rs, or 0; load in EX -> hazard.
  function automatic int fwd_of(int rs, bit used, output bit ld_hit);
    ld_hit = 1'b0;
    if (!used || rs == 0) return 0;
    for (int s = 0; s < 3; s++) begin
      if (m_v[s] && m_rd[s] == rs) begin
        if (s == 0 && m_ld[0]) begin
          ld_hit = 1'b1;
          return 0;
        end
        return s + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_eval();
    bit ha, hb;
    e_fa = fwd_of(int'(bus.ID_rs1), bus.ID_rs1_used, ha);
    e_fb = fwd_of(int'(bus.ID_rs2), bus.ID_rs2_used, hb);
    e_lu = ha | hb;
    if (!rst_n) begin
      {e_pc, e_ifid, e_fl, e_bub} = 4'b0011;
      e_fa = 0;
      e_fb = 0;
    end else if (bus.EX_Branch_Taken) {e_pc, e_ifid, e_fl, e_bub} = 4'b1011;
    else if (e_lu || m_mode != 0)     {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
    else                              {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
    e_halt = rst_n && (m_mode == 2);
  endtask

  task automatic model_commit();
    bit idle;
    idle = !(m_v[0] || m_v[1] || m_v[2]);
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        m_v[s] = 0; m_rd[s] = 0; m_ld[s] = 0;
      end
      m_mode = 0; m_stall = 0; m_flush = 0;
      return;
    end
    for (int s = 2; s > 0; s--) begin
      m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_ld[s] = m_ld[s-1];
    end
    m_v[0]  = !e_bub && bus.ID_RF_Enable && (bus.ID_rd != 0);
    m_rd[0] = int'(bus.ID_rd);
    m_ld[0] = bus.ID_Load_Instr;
    if (bus.EX_Branch_Taken) begin
      if (m_flush < CMAX) m_flush++;
    end else if (e_lu) begin
      if (m_stall < CMAX) m_stall++;
    end
    case (m_mode)
      0: if (bus.Halt_Req && !bus.EX_Branch_Taken) m_mode = 1;
      1: if (!bus.Halt_Req) m_mode = 0; else if (idle) m_mode = 2;
      default: if (!bus.Halt_Req) m_mode = 0;
    endcase
  endtask

  task automatic drive(int rs1, bit u1, int rs2, bit u2, int rd, bit we,
                       bit ld, bit br, bit hr);
    bus.ID_rs1 = rs1[RW-1:0];  bus.ID_rs1_used = u1;
    bus.ID_rs2 = rs2[RW-1:0];  bus.ID_rs2_used = u2;
    bus.ID_rd  = rd[RW-1:0];   bus.ID_RF_Enable = we;
    bus.ID_Load_Instr = ld;    bus.EX_Branch_Taken = br;
    bus.Halt_Req = hr;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3, 1, 4, 1, 3, 1, 1, 0, 1);
    settle();
    n_cmp++; if ({bus.PC_LE, bus.IFID_LE, bus.IFID_Flush, bus.IDEX_Bubble} !== 4'b0011) begin
      n_bad++; $display("FAIL rst_ctrl got=%b exp=0011", {bus.PC_LE, bus.IFID_LE, bus.IFID_Flush, bus.IDEX_Bubble});
    end
    n_cmp++; if ({bus.FWD_A, bus.FWD_B, bus.Halted} !== 5'b00000) begin
      n_bad++; $display("FAIL rst_fwd_halt got=%b exp=00000", {bus.FWD_A, bus.FWD_B, bus.Halted});
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    n_cmp++; if ({bus.Stall_Count, bus.Flush_Count} !== '0 || bus.PC_LE !== 1'b1) begin
      n_bad++; $display("FAIL rst_release got=%0d/%0d pc=%b exp=0/0 pc=1", bus.Stall_Count, bus.Flush_Count, bus.PC_LE);
    end
    tick();
  endtask

  task automatic test_forwarding();
    nops(3);
    drive(1, 1, 2, 1, 5, 1, 0, 0, 0);   // ADD x5
    settle(); tick();
    drive(5, 1, 2, 1, 6, 1, 0, 0, 0);   // SUB x6, x5, x2
    settle();
    n_cmp++; if (bus.FWD_A !== 2'b01 || bus.PC_LE !== 1'b1 || bus.IDEX_Bubble !== 1'b0) begin
      n_bad++; $display("FAIL fwd_ex got=%b pc=%b bub=%b exp=01 1 0", bus.FWD_A, bus.PC_LE, bus.IDEX_Bubble);
    end
    tick();
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    n_cmp++; if (bus.FWD_A !== 2'b10) begin
      n_bad++; $display("FAIL fwd_mem got=%b exp=10", bus.FWD_A);
    end
    tick();
    drive(0, 0, 5, 1, 0, 0, 0, 0, 0);
    settle();
    n_cmp++; if (bus.FWD_B !== 2'b11 || bus.FWD_A !== 2'b00) begin
      n_bad++; $display("FAIL fwd_wb got=%b/%b exp=00/11", bus.FWD_A, bus.FWD_B);
    end
    tick();
  endtask

  task automatic test_load_use();
    nops(3);
    drive(3, 1, 0, 0, 7, 1, 1, 0, 0);   // LW x7
    settle(); tick();
    drive(7, 1, 2, 1, 1, 1, 0, 0, 0);   // ADD x1, x7, x2
    settle();
    n_cmp++; if ({bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble, bus.IFID_Flush} !== 4'b0010) begin
      n_bad++; $display("FAIL lu_stall got=%b exp=0010", {bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble, bus.IFID_Flush});
    end
    tick();
    settle();
    n_cmp++; if (bus.FWD_A !== 2'b10 || bus.PC_LE !== 1'b1) begin
      n_bad++; $display("FAIL lu_resume got=%b pc=%b exp=10 1", bus.FWD_A, bus.PC_LE);
    end
    n_cmp++; if (bus.Stall_Count !== CW'(1)) begin
      n_bad++; $display("FAIL lu_count got=%0d exp=1", bus.Stall_Count);
    end
    tick();
  endtask

  task automatic test_flush_over_stall();
    nops(3);
    drive(3, 1, 0, 0, 7, 1, 1, 0, 0);   // LW x7
    settle(); tick();
    drive(7, 1, 2, 1, 1, 1, 0, 1, 0);   // dependent + branch taken
    settle();
    n_cmp++; if ({bus.IFID_Flush, bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble} !== 4'b1101) begin
      n_bad++; $display("FAIL br_ctrl got=%b exp=1101", {bus.IFID_Flush, bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    n_cmp++; if (bus.Flush_Count !== CW'(1) || bus.Stall_Count !== CW'(1)) begin
      n_bad++; $display("FAIL br_counts got=%0d/%0d exp=1/1", bus.Flush_Count, bus.Stall_Count);
    end
    tick();
  endtask

  task automatic test_x0();
    nops(3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 0, 1, 1, 0, 0);   // load to x0, reading x0
      settle();
      n_cmp++; if ({bus.FWD_A, bus.FWD_B} !== 4'b0000 || bus.PC_LE !== 1'b1) begin
        n_bad++; $display("FAIL x0 cyc=%0d got=%b pc=%b exp=0000 1", i, {bus.FWD_A, bus.FWD_B}, bus.PC_LE);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    nops(3);
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 0, r, 1, 0, 0, 0);
      settle(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    n_cmp++; if (bus.PC_LE !== 1'b1 || bus.Halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_req pc=%b halted=%b exp=1 0", bus.PC_LE, bus.Halted);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if ({bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble, bus.Halted} !== 4'b0010) begin
        n_bad++; $display("FAIL drain cyc=%0d got=%b exp=0010", k, {bus.PC_LE, bus.IFID_LE, bus.IDEX_Bubble, bus.Halted});
      end
      tick();
    end
    settle();
    n_cmp++; if (bus.Halted !== 1'b1 || bus.PC_LE !== 1'b0) begin
      n_bad++; $display("FAIL halted got=%b pc=%b exp=1 0", bus.Halted, bus.PC_LE);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); tick();
    settle();
    n_cmp++; if (bus.PC_LE !== 1'b1 || bus.Halted !== 1'b0) begin
      n_bad++; $display("FAIL unhalt pc=%b halted=%b exp=1 0", bus.PC_LE, bus.Halted);
    end
    tick();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    nops(1);
    rst_n = 1'b1;
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(3, 1, 0, 0, 7, 1, 1, 0, 0);
      settle(); tick();
      drive(7, 1, 2, 1, 1, 1, 0, 0, 0);
      settle(); tick();
      settle(); tick();
      if (i == CMAX - 2) begin
        n_cmp++; if (bus.Stall_Count !== CW'(CMAX - 1)) begin
          n_bad++; $display("FAIL stall_pre got=%0d exp=%0d", bus.Stall_Count, CMAX - 1);
        end
      end
    end
    n_cmp++; if (bus.Stall_Count !== CW'(CMAX)) begin
      n_bad++; $display("FAIL stall_sat got=%0d exp=%0d", bus.Stall_Count, CMAX);
    end
    for (int i = 0; i < CMAX + 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle(); tick();
    end
    n_cmp++; if (bus.Flush_Count !== CW'(CMAX)) begin
      n_bad++; $display("FAIL flush_sat got=%0d exp=%0d", bus.Flush_Count, CMAX);
    end
    // Fill the pipe, start a drain, then reset partway through it.
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 0, r, 1, 0, 0, 0);
      settle(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle(); tick();
    settle();
    n_cmp++; if (bus.PC_LE !== 1'b0 || bus.Halted !== 1'b0) begin
      n_bad++; $display("FAIL middrain pc=%b halted=%b exp=0 0", bus.PC_LE, bus.Halted);
    end
    tick();
    rst_n = 1'b0;
    settle();
    n_cmp++; if (bus.IFID_Flush !== 1'b1 || bus.Halted !== 1'b0) begin
      n_bad++; $display("FAIL rst_drain fl=%b halted=%b exp=1 0", bus.IFID_Flush, bus.Halted);
    end
    tick();
    rst_n = 1'b1;
    settle();
    n_cmp++; if (bus.Stall_Count !== '0 || bus.Flush_Count !== '0 || bus.Halted !== 1'b0 || bus.PC_LE !== 1'b1) begin
      n_bad++; $display("FAIL post_rst got=%0d/%0d halted=%b pc=%b exp=0/0 0 1", bus.Stall_Count, bus.Flush_Count, bus.Halted, bus.PC_LE);
    end
    tick();
    nops(2);
  endtask

  task automatic test_random();
    bit hr = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 19) == 0) hr = ~hr;
      drive($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), hr);
      settle();
      n_cmp++; if (bus.PC_LE !== e_pc) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%b exp=%b", c, bus.PC_LE, e_pc); end
      n_cmp++; if (bus.IFID_LE !== e_ifid) begin n_bad++; $display("FAIL rnd_ifid cyc=%0d got=%b exp=%b", c, bus.IFID_LE, e_ifid); end
      n_cmp++; if (bus.IFID_Flush !== e_fl) begin n_bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, bus.IFID_Flush, e_fl); end
      n_cmp++; if (bus.IDEX_Bubble !== e_bub) begin n_bad++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", c, bus.IDEX_Bubble, e_bub); end
      n_cmp++; if (bus.FWD_A !== 2'(e_fa)) begin n_bad++; $display("FAIL rnd_fwda cyc=%0d got=%0d exp=%0d", c, bus.FWD_A, e_fa); end
      n_cmp++; if (bus.FWD_B !== 2'(e_fb)) begin n_bad++; $display("FAIL rnd_fwdb cyc=%0d got=%0d exp=%0d", c, bus.FWD_B, e_fb); end
      n_cmp++; if (bus.Halted !== e_halt) begin n_bad++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", c, bus.Halted, e_halt); end
      n_cmp++; if (bus.Stall_Count !== CW'(m_stall)) begin n_bad++; $display("FAIL rnd_stallcnt cyc=%0d got=%0d exp=%0d", c, bus.Stall_Count, m_stall); end
      n_cmp++; if (bus.Flush_Count !== CW'(m_flush)) begin n_bad++; $display("FAIL rnd_flushcnt cyc=%0d got=%0d exp=%0d", c, bus.Flush_Count, m_flush); end
      tick();
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 0; m_rd[s] = 0; m_ld[s] = 0;
    end
    m_mode = 0; m_stall = 0; m_flush = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_over_stall();
    test_x0();
    test_halt();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
